// File: rtl/box_pkg.sv
// box_pkg: shared types and helpers for the face-box scheduler.
//   COORD_W     : coordinate / size width
//   box_t       : one box {x, y, w, h} (centre + size)
//   col_state_e : collect FSM states
//   box_span()  : vertical row span of a box, top clamped at 0, bottom unwrapped
package box_pkg;

    localparam int COORD_W = 10;
    localparam int SPAN_W  = COORD_W + 1;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } box_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } col_state_e;

    typedef struct packed {
        logic [SPAN_W-1:0] top;
        logic [SPAN_W-1:0] bottom;
    } span_t;

    function automatic span_t box_span(input box_t b);
        logic [COORD_W-1:0] half;
        span_t              s;
        half     = b.h >> 1;
        s.top    = (b.y >= half) ? {1'b0, b.y - half} : '0;
        s.bottom = {1'b0, b.y} + {1'b0, half};
        return s;
    endfunction

endpackage

// File: rtl/box_scheduler_if.sv
// box_scheduler_if: detector -> scheduler box stream (valid/ready).
//   master : detector side, drives det_valid/det_last/det_x/y/w/h
//   slave  : scheduler side, drives det_ready
interface box_scheduler_if;
    import box_pkg::*;

    logic               det_valid;
    logic               det_ready;
    logic               det_last;
    logic [COORD_W-1:0] det_x;
    logic [COORD_W-1:0] det_y;
    logic [COORD_W-1:0] det_w;
    logic [COORD_W-1:0] det_h;

    modport master (output det_valid, det_last, det_x, det_y, det_w, det_h,
                    input  det_ready);
    modport slave  (input  det_valid, det_last, det_x, det_y, det_w, det_h,
                    output det_ready);
endinterface

// File: rtl/box_row_select.sv
// box_row_select: combinational priority search of the active table.
//   tab_i : active box table
//   vld_i : per-entry valid
//   yn_i  : row being evaluated
//   hit_o : some valid entry covers yn_i
//   idx_o : lowest-index covering entry
module box_row_select
    import box_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  box_t               tab_i [N],
    input  logic [N-1:0]       vld_i,
    input  logic [COORD_W-1:0] yn_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the top index down so the lowest matching index is the last write.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            span_t sp;
            sp = box_span(tab_i[i]);
            if (vld_i[i] && ({1'b0, yn_i} >= sp.top) && ({1'b0, yn_i} <= sp.bottom)) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/box_scheduler.sv
// box_scheduler: collects detector box sets, commits them per frame and
// presents the box covering each row to the single-box overlay.
//   clk, reset (sync, active-low), pix_valid (raster pixel strobe)
//   det       : detector box stream (slave modport)
//   box_*     : box for the current row, box_en marks it valid
//   box_count : valid active entries; set_ovf : last committed set overflowed
//
//   state   | meaning
//   COLLECT | accepting boxes of the next set into the pending table
//   FULL    | set complete, waiting for end of frame to commit
module box_scheduler
    import box_pkg::*;
#(
    parameter int IMG_WIDTH   = 720,
    parameter int IMG_HEIGHT  = 540,
    parameter int MAX_BOXES   = 4,
    parameter int HOLD_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    box_scheduler_if.slave     det,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y,
    output logic [COORD_W-1:0] box_w,
    output logic [COORD_W-1:0] box_h,
    output logic               box_en,
    output logic [CNT_W-1:0]   box_count,
    output logic               set_ovf
);

    localparam int IDX_W = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;
    localparam int AGE_W = $clog2(HOLD_FRAMES + 1);

    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d, yn;
    col_state_e           state_q, state_d;
    logic                 det_ready_q, det_ready_d;
    logic [CNT_W-1:0]     wr_idx_q, wr_idx_d, pend_cnt_q, pend_cnt_d, cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d, set_ovf_q, set_ovf_d;
    box_t                 pend_q [MAX_BOXES];
    box_t                 pend_d [MAX_BOXES];
    box_t                 act_q  [MAX_BOXES];
    box_t                 act_d  [MAX_BOXES];
    logic [MAX_BOXES-1:0] act_vld_q, act_vld_d;
    logic [AGE_W-1:0]     age_q, age_d;
    box_t                 box_q, box_d, det_box;
    logic                 box_en_q, box_en_d;
    logic                 eol, eof, accept, commit, hit;
    logic [IDX_W-1:0]     hit_idx;

    always_comb begin
        eol    = pix_valid && (x_q == COORD_W'(IMG_WIDTH - 1));
        eof    = eol && (y_q == COORD_W'(IMG_HEIGHT - 1));
        accept = det.det_valid && det_ready_q && (state_q == COLLECT);
        commit = eof && (state_q == FULL);
        yn     = eof ? '0 : y_q + 1'b1;
        det_box.x = det.det_x;
        det_box.y = det.det_y;
        det_box.w = det.det_w;
        det_box.h = det.det_h;
    end

    // Raster position
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_valid) begin
            if (eol) begin
                x_d = '0;
                y_d = eof ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Collect FSM and pending table
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        pend_cnt_d = pend_cnt_q;
        ovf_pend_d = ovf_pend_q;
        pend_d     = pend_q;
        if (commit) begin
            state_d    = COLLECT;
            wr_idx_d   = '0;
            ovf_pend_d = 1'b0;
        end else if (accept) begin
            if (wr_idx_q < CNT_W'(MAX_BOXES)) begin
                pend_d[wr_idx_q[IDX_W-1:0]] = det_box;
                wr_idx_d = wr_idx_q + 1'b1;
            end else begin
                ovf_pend_d = 1'b1;
            end
            if (det.det_last) begin
                state_d    = FULL;
                pend_cnt_d = (wr_idx_q < CNT_W'(MAX_BOXES)) ? wr_idx_q + 1'b1 : CNT_W'(MAX_BOXES);
            end
        end
        det_ready_d = (state_d == COLLECT);
    end

    // Active table: commit wins over expiry on the same end of frame
    always_comb begin
        act_d     = act_q;
        act_vld_d = act_vld_q;
        cnt_d     = cnt_q;
        set_ovf_d = set_ovf_q;
        age_d     = age_q;
        if (commit) begin
            act_d = pend_q;
            for (int i = 0; i < MAX_BOXES; i++) begin
                act_vld_d[i] = (CNT_W'(i) < pend_cnt_q);
            end
            cnt_d     = pend_cnt_q;
            set_ovf_d = ovf_pend_q;
            age_d     = '0;
        end else if (eof) begin
            if (age_q < AGE_W'(HOLD_FRAMES)) begin
                age_d = age_q + 1'b1;
            end
            if (age_d == AGE_W'(HOLD_FRAMES)) begin
                act_vld_d = '0;
                cnt_d     = '0;
            end
        end
    end

    // Row select sees the table as it will be after this cycle's commit/expiry
    box_row_select #(.N(MAX_BOXES)) u_row_select (
        .tab_i (act_d),
        .vld_i (act_vld_d),
        .yn_i  (yn),
        .hit_o (hit),
        .idx_o (hit_idx)
    );

    always_comb begin
        box_en_d = box_en_q;
        box_d    = box_q;
        if (eol) begin
            box_en_d = hit;
            if (hit) begin
                box_d = act_d[hit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            state_q     <= COLLECT;
            det_ready_q <= 1'b0;
            wr_idx_q    <= '0;
            pend_cnt_q  <= '0;
            ovf_pend_q  <= 1'b0;
            pend_q      <= '{default: '0};
            act_q       <= '{default: '0};
            act_vld_q   <= '0;
            cnt_q       <= '0;
            set_ovf_q   <= 1'b0;
            age_q       <= '0;
            box_q       <= '0;
            box_en_q    <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            state_q     <= state_d;
            det_ready_q <= det_ready_d;
            wr_idx_q    <= wr_idx_d;
            pend_cnt_q  <= pend_cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            act_vld_q   <= act_vld_d;
            cnt_q       <= cnt_d;
            set_ovf_q   <= set_ovf_d;
            age_q       <= age_d;
            box_q       <= box_d;
            box_en_q    <= box_en_d;
        end
    end

    assign det.det_ready = det_ready_q;
    assign box_x         = box_q.x;
    assign box_y         = box_q.y;
    assign box_w         = box_q.w;
    assign box_h         = box_q.h;
    assign box_en        = box_en_q;
    assign box_count     = cnt_q;
    assign set_ovf       = set_ovf_q;

endmodule

// File: tb/tb_box_scheduler.sv
// tb_box_scheduler: scoreboard bench for box_scheduler on a reduced 4x140 raster.
// Stimulus pushes hand-computed per-row expectations; a negedge monitor pops
// and compares them at the first pixel of the tagged frame/row.
module tb_box_scheduler;
    import box_pkg::*;

    localparam int W = 4;
    localparam int H = 140;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               pix_valid = 1'b0;
    logic [COORD_W-1:0] box_x, box_y, box_w, box_h;
    logic               box_en;
    logic [2:0]         box_count;
    logic               set_ovf;

    box_scheduler_if ifc ();

    box_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAX_BOXES(4), .HOLD_FRAMES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .det       (ifc.slave),
        .box_x     (box_x),
        .box_y     (box_y),
        .box_w     (box_w),
        .box_h     (box_h),
        .box_en    (box_en),
        .box_count (box_count),
        .set_ovf   (set_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         frame;
        int         row;
        logic       en;
        box_t       b;
        logic [2:0] cnt;
        logic       ovf;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_x = 0, tb_y = 0, tb_frame = 0;

    // Bench-side raster position; a reset that interrupts a frame starts a new frame number.
    always @(posedge clk) begin
        if (!reset) begin
            if (tb_x != 0 || tb_y != 0) tb_frame <= tb_frame + 1;
            tb_x <= 0;
            tb_y <= 0;
        end else if (pix_valid) begin
            if (tb_x == W - 1) begin
                tb_x <= 0;
                if (tb_y == H - 1) begin
                    tb_y     <= 0;
                    tb_frame <= tb_frame + 1;
                end else begin
                    tb_y <= tb_y + 1;
                end
            end else begin
                tb_x <= tb_x + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic box_t mk(input int x, input int y, input int w, input int h);
        box_t b;
        b.x = COORD_W'(x);
        b.y = COORD_W'(y);
        b.w = COORD_W'(w);
        b.h = COORD_W'(h);
        return b;
    endfunction

    task automatic push_exp(input int f, input int r, input logic en, input box_t b,
                            input int cnt, input logic ovf, input logic rdy);
        exp_t e;
        e.frame = f;
        e.row   = r;
        e.en    = en;
        e.b     = b;
        e.cnt   = 3'(cnt);
        e.ovf   = ovf;
        e.rdy   = rdy;
        q.push_back(e);
    endtask

    // Monitor: compare at the first pixel of each row that has an expectation
    always @(negedge clk) begin
        if (reset && pix_valid && tb_x == 0) begin
            while (q.size() > 0 && (q[0].frame * 1000 + q[0].row) < (tb_frame * 1000 + tb_y)) begin
                me = q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed f%0d r%0d: row not observed, now at f%0d r%0d",
                         me.frame, me.row, tb_frame, tb_y);
            end
            if (q.size() > 0 && q[0].frame == tb_frame && q[0].row == tb_y) begin
                me = q.pop_front();
                check($sformatf("f%0d r%0d box_en", me.frame, me.row), 64'(box_en), 64'(me.en));
                check($sformatf("f%0d r%0d box", me.frame, me.row),
                      64'({box_x, box_y, box_w, box_h}), 64'(me.b));
                check($sformatf("f%0d r%0d box_count", me.frame, me.row), 64'(box_count), 64'(me.cnt));
                check($sformatf("f%0d r%0d set_ovf", me.frame, me.row), 64'(set_ovf), 64'(me.ovf));
                check($sformatf("f%0d r%0d det_ready", me.frame, me.row), 64'(ifc.det_ready), 64'(me.rdy));
            end
        end
    end

    task automatic wait_pos(input int f, input int r, input int x);
        int n = 0;
        while (!(tb_frame == f && tb_y == r && tb_x == x)) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_pos f%0d r%0d x%0d: timeout", f, r, x);
                return;
            end
        end
    endtask

    task automatic send_box(input box_t b, input logic last);
        bit acc = 1'b0;
        int n   = 0;
        ifc.det_valid = 1'b1;
        ifc.det_x     = b.x;
        ifc.det_y     = b.y;
        ifc.det_w     = b.w;
        ifc.det_h     = b.h;
        ifc.det_last  = last;
        while (!acc) begin
            acc = ifc.det_ready;
            @(posedge clk);
            n++;
            if (!acc) begin
                @(negedge clk);
                if (n > 5000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_box: det_ready never seen, got 0 expected 1");
                    break;
                end
            end
        end
        @(negedge clk);
        ifc.det_valid = 1'b0;
        ifc.det_last  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " box_en"}, 64'(box_en), 64'(0));
        check({tag, " box"}, 64'({box_x, box_y, box_w, box_h}), 64'(0));
        check({tag, " box_count"}, 64'(box_count), 64'(0));
        check({tag, " set_ovf"}, 64'(set_ovf), 64'(0));
        check({tag, " det_ready"}, 64'(ifc.det_ready), 64'(0));
    endtask

    initial begin
        box_t z, s, e1, a, b, c;
        box_t ob [6];
        int   n;
        z  = mk(0, 0, 0, 0);
        s  = mk(100, 100, 40, 40);
        e1 = mk(50, 110, 40, 40);
        a  = mk(200, 30, 20, 20);
        b  = mk(300, 60, 20, 20);
        c  = mk(400, 5, 40, 40);
        for (int i = 0; i < 6; i++) ob[i] = mk(11 + i, 20 + 20 * i, 10, 10);

        ifc.det_valid = 1'b0;
        ifc.det_last  = 1'b0;
        ifc.det_x     = '0;
        ifc.det_y     = '0;
        ifc.det_w     = '0;
        ifc.det_h     = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("init reset");

        push_exp(0, 0, 0, z, 0, 0, 1);
        push_exp(0, 5, 0, z, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 pix_valid = 1'b1;
        @(negedge clk);

        // Single box
        wait_pos(0, 1, 0);
        send_box(s, 1'b1);
        push_exp(1, 0,   0, z, 1, 0, 1);
        push_exp(1, 79,  0, z, 1, 0, 0);
        push_exp(1, 80,  1, s, 1, 0, 0);
        push_exp(1, 120, 1, s, 1, 0, 0);
        push_exp(1, 121, 0, s, 1, 0, 0);

        // Overlapping boxes
        wait_pos(1, 1, 0);
        send_box(s, 1'b0);
        send_box(e1, 1'b1);
        push_exp(2, 0,   0, s,  2, 0, 1);
        push_exp(2, 80,  1, s,  2, 0, 0);
        push_exp(2, 120, 1, s,  2, 0, 0);
        push_exp(2, 121, 1, e1, 2, 0, 0);
        push_exp(2, 130, 1, e1, 2, 0, 0);
        push_exp(2, 131, 0, e1, 2, 0, 0);

        // Overflow: six boxes, only the first four survive
        wait_pos(2, 1, 0);
        for (int i = 0; i < 6; i++) send_box(ob[i], (i == 5));
        push_exp(3, 0,   0, e1,    4, 1, 1);
        push_exp(3, 15,  1, ob[0], 4, 1, 1);
        push_exp(3, 25,  1, ob[0], 4, 1, 1);
        push_exp(3, 26,  0, ob[0], 4, 1, 1);
        push_exp(3, 35,  1, ob[1], 4, 1, 1);
        push_exp(3, 80,  1, ob[3], 4, 1, 1);
        push_exp(3, 100, 0, ob[3], 4, 1, 1);
        push_exp(3, 120, 0, ob[3], 4, 1, 1);

        // Expiry: eofs of frames 3..10 are the eight without a commit
        push_exp(10, 0,  0, ob[3], 4, 1, 1);
        push_exp(10, 80, 1, ob[3], 4, 1, 1);
        push_exp(11, 0,  0, ob[3], 0, 1, 1);

        wait_pos(11, 1, 0);
        send_box(a, 1'b1);
        push_exp(11, 80,  0, ob[3], 0, 1, 0);
        push_exp(11, 139, 0, ob[3], 0, 1, 0);
        push_exp(12, 0,   0, ob[3], 1, 0, 1);
        push_exp(12, 20,  1, a, 1, 0, 1);
        push_exp(12, 40,  1, a, 1, 0, 1);
        push_exp(12, 41,  0, a, 1, 0, 1);
        push_exp(12, 139, 0, a, 1, 0, 1);

        // det_last accepted on the eof pixel: old set shown one more frame
        wait_pos(12, 139, 3);
        send_box(b, 1'b1);
        push_exp(13, 0,   0, a, 1, 0, 0);
        push_exp(13, 20,  1, a, 1, 0, 0);
        push_exp(13, 50,  0, a, 1, 0, 0);
        push_exp(13, 139, 0, a, 1, 0, 0);
        push_exp(14, 0,   0, a, 1, 0, 1);
        push_exp(14, 20,  0, a, 1, 0, 1);
        push_exp(14, 50,  1, b, 1, 0, 1);

        // Top clamp: y=5 h=40 covers rows 0..25
        wait_pos(14, 60, 0);
        send_box(c, 1'b1);
        push_exp(14, 100, 0, b, 1, 0, 0);
        push_exp(15, 0,   1, c, 1, 0, 1);
        push_exp(15, 25,  1, c, 1, 0, 1);
        push_exp(15, 26,  0, c, 1, 0, 1);

        // Mid-frame reset
        wait_pos(15, 60, 0);
        pix_valid = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("mid reset");
        push_exp(16, 0,  0, z, 0, 0, 1);
        push_exp(16, 25, 0, z, 0, 0, 1);
        push_exp(17, 0,  0, z, 0, 0, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 pix_valid = 1'b1;
        @(negedge clk);

        wait_pos(17, 1, 0);
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
